// File: rtl/rtc_bus_scheduler_pkg.sv
// Shared types and constants for the V3023 RTC bus scheduler.
package rtc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_START,
        ST_W_WAIT,
        ST_R_START,
        ST_R_WAIT,
        ST_R_NEXT
    } state_t;

    localparam int unsigned SCAN_LEN = 6;

    typedef logic [2:0] scan_idx_t;

    localparam scan_idx_t LAST_IDX = scan_idx_t'(SCAN_LEN - 1);

    // Time register addresses read by a refresh scan, in shadow-bank order:
    // seg, min, hora, dia, mes, anio.
    function automatic logic [7:0] scan_addr(input scan_idx_t idx);
        case (idx)
            3'd0:    scan_addr = 8'h21;
            3'd1:    scan_addr = 8'h22;
            3'd2:    scan_addr = 8'h23;
            3'd3:    scan_addr = 8'h24;
            3'd4:    scan_addr = 8'h25;
            3'd5:    scan_addr = 8'h26;
            default: scan_addr = 8'h21;
        endcase
    endfunction

endpackage

// File: rtl/rtc_bus_scheduler_if.sv
// Handshake between the scheduler and the V3023 bus-cycle engine.
interface rtc_bus_scheduler_if;

    logic       eng_start;
    logic       eng_is_write;
    logic [7:0] eng_addr;
    logic [7:0] eng_wdata;
    logic       eng_done;
    logic [7:0] eng_rdata;
    logic       eng_abort;

    modport master (
        output eng_start,
        output eng_is_write,
        output eng_addr,
        output eng_wdata,
        output eng_abort,
        input  eng_done,
        input  eng_rdata
    );

    modport slave (
        input  eng_start,
        input  eng_is_write,
        input  eng_addr,
        input  eng_wdata,
        input  eng_abort,
        output eng_done,
        output eng_rdata
    );

endinterface

// File: rtl/rtc_bus_scheduler_timeout_cnt.sv
// Engine watchdog: counts WAIT cycles and flags when the limit is reached.
module rtc_timeout_cnt #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic Clock_in,
    input  logic Reset,
    input  logic clr,
    input  logic en,
    output logic at_limit
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Count register.
    always_ff @(posedge Clock_in) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == TIMEOUT);

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Shares the V3023 bus-cycle engine between host writes and periodic
// time-register refresh scans, keeping a shadow copy of the time registers.
module rtc_bus_scheduler
    import rtc_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic                       Clock_in,
    input  logic                       Reset,
    input  logic                       refresh_tick,
    input  logic                       wr_req,
    input  logic [7:0]                 wr_addr,
    input  logic [7:0]                 wr_data,
    output logic                       wr_ack,
    rtc_bus_scheduler_if.master        eng,
    output logic [7:0]                 seg,
    output logic [7:0]                 min,
    output logic [7:0]                 hora,
    output logic [7:0]                 dia,
    output logic [7:0]                 mes,
    output logic [7:0]                 anio,
    output logic                       upd_valid,
    output logic                       err
);

    state_t     state_q,          state_d;
    scan_idx_t  idx_q,            idx_d;
    logic       refresh_pend_q,   refresh_pend_d;
    logic       last_was_write_q, last_was_write_d;
    logic       eng_is_write_q,   eng_is_write_d;
    logic [7:0] eng_addr_q,       eng_addr_d;
    logic [7:0] eng_wdata_q,      eng_wdata_d;
    logic       wr_ack_q,         wr_ack_d;
    logic       eng_abort_q,      eng_abort_d;
    logic       err_q,            err_d;
    logic       upd_valid_q,      upd_valid_d;
    logic [7:0] shadow_q [SCAN_LEN];
    logic [7:0] shadow_d [SCAN_LEN];

    logic cnt_clr;
    logic cnt_en;
    logic at_limit;
    logic grant_rd;

    rtc_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .Clock_in (Clock_in),
        .Reset    (Reset),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .at_limit (at_limit)
    );

    // Arbitration, transaction sequencing and output pulse generation.
    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        refresh_pend_d   = refresh_pend_q | refresh_tick;
        last_was_write_d = last_was_write_q;
        eng_is_write_d   = eng_is_write_q;
        eng_addr_d       = eng_addr_q;
        eng_wdata_d      = eng_wdata_q;
        wr_ack_d         = 1'b0;
        eng_abort_d      = 1'b0;
        err_d            = 1'b0;
        upd_valid_d      = 1'b0;
        shadow_d         = shadow_q;
        cnt_clr          = 1'b0;
        cnt_en           = 1'b0;
        grant_rd         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Alternate when both are waiting; otherwise serve whichever is present.
                grant_rd = refresh_pend_q && (!wr_req || last_was_write_q);
                if (grant_rd) begin
                    state_d          = ST_R_START;
                    idx_d            = '0;
                    refresh_pend_d   = refresh_tick;
                    last_was_write_d = 1'b0;
                    eng_is_write_d   = 1'b0;
                    eng_addr_d       = scan_addr('0);
                end else if (wr_req) begin
                    state_d          = ST_W_START;
                    last_was_write_d = 1'b1;
                    eng_is_write_d   = 1'b1;
                    eng_addr_d       = wr_addr;
                    eng_wdata_d      = wr_data;
                end
            end

            ST_W_START: begin
                cnt_clr = 1'b1;
                state_d = ST_W_WAIT;
            end

            ST_W_WAIT: begin
                cnt_en = 1'b1;
                if (eng.eng_done) begin
                    wr_ack_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (at_limit) begin
                    wr_ack_d    = 1'b1;
                    eng_abort_d = 1'b1;
                    err_d       = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            ST_R_START: begin
                cnt_clr = 1'b1;
                state_d = ST_R_WAIT;
            end

            ST_R_WAIT: begin
                cnt_en = 1'b1;
                if (eng.eng_done) begin
                    if (idx_q <= LAST_IDX) begin
                        shadow_d[idx_q] = eng.eng_rdata;
                    end
                    state_d = ST_R_NEXT;
                end else if (at_limit) begin
                    // Scan is dropped; already-updated shadows keep their new values.
                    eng_abort_d = 1'b1;
                    err_d       = 1'b1;
                    idx_d       = '0;
                    state_d     = ST_IDLE;
                end
            end

            ST_R_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    upd_valid_d = 1'b1;
                    idx_d       = '0;
                    state_d     = ST_IDLE;
                end else begin
                    idx_d          = idx_q + 3'd1;
                    eng_is_write_d = 1'b0;
                    eng_addr_d     = scan_addr(idx_q + 3'd1);
                    state_d        = ST_R_START;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything without aborting the engine.
    always_ff @(posedge Clock_in) begin
        if (Reset) begin
            state_q          <= ST_IDLE;
            idx_q            <= '0;
            refresh_pend_q   <= 1'b0;
            last_was_write_q <= 1'b0;
            eng_is_write_q   <= 1'b0;
            eng_addr_q       <= '0;
            eng_wdata_q      <= '0;
            wr_ack_q         <= 1'b0;
            eng_abort_q      <= 1'b0;
            err_q            <= 1'b0;
            upd_valid_q      <= 1'b0;
            shadow_q         <= '{default: '0};
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            refresh_pend_q   <= refresh_pend_d;
            last_was_write_q <= last_was_write_d;
            eng_is_write_q   <= eng_is_write_d;
            eng_addr_q       <= eng_addr_d;
            eng_wdata_q      <= eng_wdata_d;
            wr_ack_q         <= wr_ack_d;
            eng_abort_q      <= eng_abort_d;
            err_q            <= err_d;
            upd_valid_q      <= upd_valid_d;
            shadow_q         <= shadow_d;
        end
    end

    assign eng.eng_start    = (state_q == ST_W_START) || (state_q == ST_R_START);
    assign eng.eng_is_write = eng_is_write_q;
    assign eng.eng_addr     = eng_addr_q;
    assign eng.eng_wdata    = eng_wdata_q;
    assign eng.eng_abort    = eng_abort_q;

    assign wr_ack    = wr_ack_q;
    assign err       = err_q;
    assign upd_valid = upd_valid_q;
    assign seg       = shadow_q[0];
    assign min       = shadow_q[1];
    assign hora      = shadow_q[2];
    assign dia       = shadow_q[3];
    assign mes       = shadow_q[4];
    assign anio      = shadow_q[5];

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Self-checking bench for rtc_bus_scheduler: the bench plays the bus-cycle
// engine and predicts grants, addresses and shadow contents from the
// scheduling rules.
module tb_rtc_bus_scheduler;

    logic       Clock_in     = 1'b0;
    logic       Reset        = 1'b1;
    logic       refresh_tick = 1'b0;
    logic       wr_req       = 1'b0;
    logic [7:0] wr_addr      = '0;
    logic [7:0] wr_data      = '0;
    logic       wr_ack;
    logic       upd_valid;
    logic       err;
    logic [7:0] seg, min, hora, dia, mes, anio;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] m_shadow [6];
    bit         m_last_write = 1'b0;
    int         force_read   = -1;
    int         force_k      = 0;

    rtc_bus_scheduler_if eng_bus ();

    rtc_bus_scheduler #(
        .TIMEOUT (8'd255)
    ) dut (
        .Clock_in     (Clock_in),
        .Reset        (Reset),
        .refresh_tick (refresh_tick),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ack       (wr_ack),
        .eng          (eng_bus),
        .seg          (seg),
        .min          (min),
        .hora         (hora),
        .dia          (dia),
        .mes          (mes),
        .anio         (anio),
        .upd_valid    (upd_valid),
        .err          (err)
    );

    always #5 Clock_in = ~Clock_in;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed no finish, expected finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge Clock_in);
    endtask

    function automatic logic [7:0] shadow_at(input int i);
        case (i)
            0:       return seg;
            1:       return min;
            2:       return hora;
            3:       return dia;
            4:       return mes;
            default: return anio;
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, " wr_ack"},       32'(wr_ack), 32'd0);
        chk({tag, " eng_start"},    32'(eng_bus.eng_start), 32'd0);
        chk({tag, " eng_is_write"}, 32'(eng_bus.eng_is_write), 32'd0);
        chk({tag, " eng_addr"},     32'(eng_bus.eng_addr), 32'd0);
        chk({tag, " eng_wdata"},    32'(eng_bus.eng_wdata), 32'd0);
        chk({tag, " eng_abort"},    32'(eng_bus.eng_abort), 32'd0);
        chk({tag, " upd_valid"},    32'(upd_valid), 32'd0);
        chk({tag, " err"},          32'(err), 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s shadow%0d", tag, i), 32'(shadow_at(i)), 32'd0);
        end
    endtask

    task automatic pulse_tick();
        refresh_tick = 1'b1;
        step();
        refresh_tick = 1'b0;
    endtask

    task automatic raise_wr(input logic [7:0] a, input logic [7:0] d);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    // Checks the current cycle first, then steps, so a start that follows
    // immediately on the previous observation point is not missed.
    task automatic wait_start(input string tag, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (eng_bus.eng_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk({tag, " start seen"}, 32'(seen), 32'd1);
    endtask

    // Called at the eng_start cycle; raises eng_done in WAIT cycle k and
    // returns in the cycle after eng_done.
    task automatic respond(input string tag, input int k, input logic [7:0] rd,
                           input logic [7:0] exp_addr, input bit done_in_start);
        if (done_in_start) begin
            eng_bus.eng_done  = 1'b1;
            eng_bus.eng_rdata = 8'hEE;
        end
        step();
        eng_bus.eng_done = 1'b0;
        chk({tag, " start width"}, 32'(eng_bus.eng_start), 32'd0);
        repeat (k) step();
        chk({tag, " addr hold"}, 32'(eng_bus.eng_addr), 32'(exp_addr));
        eng_bus.eng_done  = 1'b1;
        eng_bus.eng_rdata = rd;
        step();
        eng_bus.eng_done  = 1'b0;
        eng_bus.eng_rdata = 8'($urandom);
    endtask

    // Serves a host write already requested on wr_req/wr_addr/wr_data.
    task automatic do_write(input string tag, input logic [7:0] a, input logic [7:0] d,
                            input int k, input bit done_in_start);
        bit seen;
        wait_start(tag, seen);
        m_last_write = 1'b1;
        if (!seen) begin
            wr_req = 1'b0;
            return;
        end
        chk({tag, " is_write"}, 32'(eng_bus.eng_is_write), 32'd1);
        chk({tag, " addr"},     32'(eng_bus.eng_addr), 32'(a));
        chk({tag, " wdata"},    32'(eng_bus.eng_wdata), 32'(d));
        respond(tag, k, 8'h00, a, done_in_start);
        chk({tag, " wr_ack"}, 32'(wr_ack), 32'd1);
        chk({tag, " err"},    32'(err), 32'd0);
        wr_req = 1'b0;
        step();
        chk({tag, " wr_ack width"}, 32'(wr_ack), 32'd0);
    endtask

    // Serves a refresh scan; optionally raises a host write at read wr_at and
    // returns early at the start of read stop_at.
    task automatic do_scan(input string tag, input int wr_at, input logic [7:0] wa,
                           input logic [7:0] wd, input int stop_at, input bit fixed);
        m_last_write = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bit         seen;
            logic [7:0] ea;
            logic [7:0] rd;
            int         k;
            ea = 8'h21 + 8'(i);
            wait_start($sformatf("%s rd%0d", tag, i), seen);
            if (!seen) return;
            chk($sformatf("%s rd%0d addr", tag, i),     32'(eng_bus.eng_addr), 32'(ea));
            chk($sformatf("%s rd%0d is_write", tag, i), 32'(eng_bus.eng_is_write), 32'd0);
            if (i == stop_at) return;
            if (i == wr_at) raise_wr(wa, wd);
            k  = (i == force_read) ? force_k : int'($urandom_range(0, 9));
            rd = fixed ? (8'h10 + 8'(i)) : 8'($urandom);
            respond($sformatf("%s rd%0d", tag, i), k, rd, ea, 1'b0);
            m_shadow[i] = rd;
            chk($sformatf("%s shadow%0d", tag, i), 32'(shadow_at(i)), 32'(m_shadow[i]));
            chk($sformatf("%s rd%0d upd_valid", tag, i), 32'(upd_valid), 32'd0);
            chk($sformatf("%s rd%0d err", tag, i), 32'(err), 32'd0);
        end
        step();
        chk({tag, " upd_valid"}, 32'(upd_valid), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s final shadow%0d", tag, i), 32'(shadow_at(i)), 32'(m_shadow[i]));
        end
        step();
        chk({tag, " upd_valid width"}, 32'(upd_valid), 32'd0);
    endtask

    task automatic timeout_write(input string tag, input bit same_cycle);
        bit         seen;
        logic [7:0] a;
        logic [7:0] d;
        a = 8'($urandom);
        d = 8'($urandom);
        raise_wr(a, d);
        wait_start(tag, seen);
        m_last_write = 1'b1;
        if (!seen) begin
            wr_req = 1'b0;
            return;
        end
        if (same_cycle) begin
            respond(tag, 255, 8'h00, a, 1'b0);
            chk({tag, " wr_ack"}, 32'(wr_ack), 32'd1);
            chk({tag, " abort"},  32'(eng_bus.eng_abort), 32'd0);
            chk({tag, " err"},    32'(err), 32'd0);
            wr_req = 1'b0;
            step();
        end else begin
            step();
            repeat (255) step();
            chk({tag, " early abort"}, 32'(eng_bus.eng_abort), 32'd0);
            step();
            chk({tag, " abort"},  32'(eng_bus.eng_abort), 32'd1);
            chk({tag, " err"},    32'(err), 32'd1);
            chk({tag, " wr_ack"}, 32'(wr_ack), 32'd1);
            wr_req = 1'b0;
            step();
            chk({tag, " abort width"}, 32'(eng_bus.eng_abort), 32'd0);
            chk({tag, " err width"},   32'(err), 32'd0);
        end
    endtask

    initial begin
        eng_bus.eng_done  = 1'b0;
        eng_bus.eng_rdata = 8'h00;
        for (int i = 0; i < 6; i++) m_shadow[i] = 8'h00;

        repeat (3) step();
        check_all_zero("reset");
        Reset = 1'b0;
        step();

        // Single write; eng_done during the start cycle must be ignored.
        raise_wr(8'h23, 8'h15);
        do_write("wr40", 8'h23, 8'h15, 39, 1'b1);

        // Refresh scan with known read data.
        pulse_tick();
        do_scan("scan", -1, 8'h00, 8'h00, 6, 1'b1);
        chk("scan seg",  32'(seg),  32'h10);
        chk("scan anio", 32'(anio), 32'h15);

        // Write arriving during read #2 waits for the scan to finish.
        pulse_tick();
        do_scan("midwr", 1, 8'h30, 8'h5A, 6, 1'b0);
        do_write("midwr wr", 8'h30, 8'h5A, int'($urandom_range(0, 9)), 1'b0);

        // Last grant was a write: refresh wins.
        pulse_tick();
        raise_wr(8'h41, 8'h99);
        do_scan("arbA", -1, 8'h00, 8'h00, 6, 1'b0);
        do_write("arbA wr", 8'h41, 8'h99, 3, 1'b0);

        // Last grant was a refresh: write wins.
        pulse_tick();
        do_scan("arbB pre", -1, 8'h00, 8'h00, 6, 1'b0);
        pulse_tick();
        raise_wr(8'h42, 8'h77);
        do_write("arbB wr", 8'h42, 8'h77, 5, 1'b0);
        do_scan("arbB", -1, 8'h00, 8'h00, 6, 1'b0);

        // Timeouts.
        timeout_write("wr_to", 1'b0);
        timeout_write("wr_lim_done", 1'b1);

        pulse_tick();
        do_scan("rd_to", -1, 8'h00, 8'h00, 1, 1'b0);
        step();
        repeat (255) step();
        chk("rd_to early abort", 32'(eng_bus.eng_abort), 32'd0);
        step();
        chk("rd_to abort",     32'(eng_bus.eng_abort), 32'd1);
        chk("rd_to err",       32'(err), 32'd1);
        chk("rd_to upd_valid", 32'(upd_valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rd_to shadow%0d", i), 32'(shadow_at(i)), 32'(m_shadow[i]));
        end
        step();
        chk("rd_to abort width", 32'(eng_bus.eng_abort), 32'd0);

        force_read = 2;
        force_k    = 255;
        pulse_tick();
        do_scan("rd_lim_done", -1, 8'h00, 8'h00, 6, 1'b0);
        force_read = -1;

        // Reset during read #4.
        pulse_tick();
        do_scan("rst", -1, 8'h00, 8'h00, 3, 1'b0);
        step();
        step();
        Reset = 1'b1;
        step();
        check_all_zero("rst mid");
        Reset = 1'b0;
        for (int i = 0; i < 6; i++) m_shadow[i] = 8'h00;
        m_last_write = 1'b0;
        begin
            int starts;
            starts = 0;
            repeat (6) begin
                step();
                if (eng_bus.eng_start === 1'b1) starts++;
            end
            chk("rst no pending refresh", 32'(starts), 32'd0);
        end
        pulse_tick();
        do_scan("rst rescan", -1, 8'h00, 8'h00, 6, 1'b0);

        // Randomised mix of requests against the arbitration model.
        for (int n = 0; n < 16; n++) begin
            int         mode;
            logic [7:0] a;
            logic [7:0] d;
            mode = int'($urandom_range(0, 3));
            a    = 8'($urandom);
            d    = 8'($urandom);
            case (mode)
                0: begin
                    raise_wr(a, d);
                    do_write($sformatf("rnd%0d wr", n), a, d, int'($urandom_range(0, 12)), 1'b0);
                end
                1: begin
                    pulse_tick();
                    do_scan($sformatf("rnd%0d scan", n), -1, 8'h00, 8'h00, 6, 1'b0);
                end
                2: begin
                    pulse_tick();
                    raise_wr(a, d);
                    if (m_last_write) begin
                        do_scan($sformatf("rnd%0d both scan", n), -1, 8'h00, 8'h00, 6, 1'b0);
                        do_write($sformatf("rnd%0d both wr", n), a, d, int'($urandom_range(0, 12)), 1'b0);
                    end else begin
                        do_write($sformatf("rnd%0d both wr", n), a, d, int'($urandom_range(0, 12)), 1'b0);
                        do_scan($sformatf("rnd%0d both scan", n), -1, 8'h00, 8'h00, 6, 1'b0);
                    end
                end
                default: begin
                    pulse_tick();
                    do_scan($sformatf("rnd%0d mid scan", n), int'($urandom_range(0, 5)), a, d, 6, 1'b0);
                    do_write($sformatf("rnd%0d mid wr", n), a, d, int'($urandom_range(0, 12)), 1'b0);
                end
            endcase
        end

        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
